// File: rtl/four_bit_adder_subtractor.sv
// four_bit_adder_subtractor: ripple-carry 4-bit add/sub; B is inverted and carry-in set when subtracting.
// Result and carry-out are registered once, giving a fixed one-cycle latency.
module four_bit_adder_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       subtract,
    output logic [3:0] Result,
    output logic       Cout
);
    logic [3:0] bx;
    logic [3:0] result_d, result_q;
    logic [4:0] c;
    logic       cout_d, cout_q;
    assign bx   = B ^ {4{subtract}};
    assign c[0] = subtract;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign result_d[i] = A[i] ^ bx[i] ^ c[i];
            assign c[i+1]      = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
        end
    endgenerate
    assign cout_d = c[4];
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 4'b0000;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end
    assign Result = result_q;
    assign Cout   = cout_q;
endmodule

// File: tb/tb_four_bit_adder_subtractor.sv
// tb_four_bit_adder_subtractor: directed, random and exhaustive checks against an arithmetic model.
module tb_four_bit_adder_subtractor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic       subtract = 1'b0;
    logic [3:0] Result;
    logic       Cout;
    int checks = 0;
    int errors = 0;

    four_bit_adder_subtractor dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .subtract(subtract),
        .Result(Result), .Cout(Cout)
    );

    always #5 clk = ~clk;

    // Subtract: Cout means "no borrow", i.e. A >= B.
    function automatic logic [4:0] model(input int a, input int b, input bit s);
        int d;
        if (!s) return 5'(a + b);
        d = (a - b) & 15;
        return {a >= b, 4'(d)};
    endfunction

    task automatic drive(input int a, input int b, input bit s, input bit r);
        @(negedge clk);
        A = 4'(a);
        B = 4'(b);
        subtract = s;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(9, 4, 0, 1);
            checks++;
            if ({Cout, Result} !== 5'd0) begin
                errors++;
                $display("FAIL reset_%0d got cout=%0d result=%0d want cout=0 result=0", k, Cout, Result);
            end
        end
        drive(9, 4, 0, 0);
        checks++;
        if ({Cout, Result} !== {1'b0, 4'd13}) begin
            errors++;
            $display("FAIL reset_release got cout=%0d result=%0d want cout=0 result=13", Cout, Result);
        end
    endtask

    task automatic test_directed();
        int v[9][5] = '{
            '{5, 3, 0, 0, 8}, '{15, 1, 0, 1, 0}, '{15, 15, 0, 1, 14},
            '{7, 2, 1, 1, 5}, '{0, 0, 1, 1, 0}, '{2, 7, 1, 0, 11},
            '{0, 1, 1, 0, 15}, '{9, 9, 1, 1, 0}, '{0, 0, 0, 0, 0}
        };
        for (int k = 0; k < 9; k++) begin
            drive(v[k][0], v[k][1], v[k][2] != 0, 0);
            checks++;
            if (Cout !== v[k][3][0] || Result !== 4'(v[k][4])) begin
                errors++;
                $display("FAIL directed_%0d a=%0d b=%0d sub=%0d got cout=%0d result=%0d want cout=%0d result=%0d",
                         k, v[k][0], v[k][1], v[k][2], Cout, Result, v[k][3], v[k][4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_q[$];
        logic [4:0] e;
        int a, b;
        bit s, r;
        for (int k = 0; k < 60; k++) begin
            a = $urandom_range(15);
            b = $urandom_range(15);
            s = $urandom_range(1);
            r = (k == 25);
            exp_q.push_back(r ? 5'd0 : model(a, b, s));
            drive(a, b, s, r);
            e = exp_q.pop_front();
            checks++;
            if ({Cout, Result} !== e) begin
                errors++;
                $display("FAIL b2b_%0d a=%0d b=%0d sub=%0d rst=%0d got %0d want %0d", k, a, b, s, r, {Cout, Result}, e);
            end
        end
    endtask

    task automatic test_sweep();
        logic [4:0] e;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    drive(a, b, s[0], 0);
                    e = model(a, b, s[0]);
                    checks++;
                    if ({Cout, Result} !== e) begin
                        errors++;
                        $display("FAIL sweep a=%0d b=%0d sub=%0d got %0d want %0d", a, b, s, {Cout, Result}, e);
                    end
                end
    endtask

    task automatic test_hold();
        drive(6, 11, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({Cout, Result} !== model(6, 11, 1)) begin
            errors++;
            $display("FAIL hold got %0d want %0d", {Cout, Result}, model(6, 11, 1));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_sweep();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
